// File: rtl/doc_trace_capture_if.sv
// Sample bus and FWFT read port of the trace-capture block.
// master: the sound generator and the trace reader; slave: the capture block.
interface doc_trace_capture_if #(
  parameter int NUM_OSC  = 32,
  parameter int SAMPLE_W = 16
);
  localparam int IDX_W = (NUM_OSC > 1) ? $clog2(NUM_OSC) : 1;
  localparam int REC_W = IDX_W + 3 + 8 + 8 + SAMPLE_W;

  logic                smp_valid_i;
  logic [IDX_W-1:0]    smp_osc_i;
  logic [2:0]          smp_state_i;
  logic [7:0]          smp_vol_i;
  logic [7:0]          smp_wds_i;
  logic [SAMPLE_W-1:0] smp_out_i;

  logic                rd_valid_o;
  logic                rd_ready_i;
  logic [REC_W-1:0]    rd_data_o;

  modport master (
    output smp_valid_i, smp_osc_i, smp_state_i, smp_vol_i, smp_wds_i, smp_out_i,
    output rd_ready_i,
    input  rd_valid_o, rd_data_o
  );

  modport slave (
    input  smp_valid_i, smp_osc_i, smp_state_i, smp_vol_i, smp_wds_i, smp_out_i,
    input  rd_ready_i,
    output rd_valid_o, rd_data_o
  );
endinterface

// File: rtl/doc_trace_capture.sv
// Trigger-qualified trace buffer for oscillator samples, one-shot or ring mode,
// with a first-word-fall-through read port.
module doc_trace_capture #(
  parameter  int NUM_OSC  = 32,
  parameter  int DEPTH    = 64,
  parameter  int SAMPLE_W = 16,
  localparam int IDX_W    = (NUM_OSC > 1) ? $clog2(NUM_OSC) : 1,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  doc_trace_capture_if.slave  bus,
  input  logic [NUM_OSC-1:0]  osc_mask_i,
  input  logic                mode_i,
  input  logic [IDX_W-1:0]    trig_osc_i,
  input  logic [SAMPLE_W-1:0] trig_level_i,
  input  logic                arm_i,
  input  logic                stop_i,
  output logic [1:0]          state_o,
  output logic                done_o,
  output logic [CNT_W-1:0]    count_o,
  output logic [15:0]         drop_cnt_o
);
  localparam int REC_W = IDX_W + 3 + 8 + 8 + SAMPLE_W;
  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [REC_W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [15:0]          r_drop;
  logic                 r_mode;

  logic                 w_mask_hit;
  logic                 w_qual;
  logic [SAMPLE_W:0]    w_ext;
  logic [SAMPLE_W:0]    w_mag;
  logic                 w_trig;
  logic                 w_rd_valid;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_wr;
  logic                 w_clear;
  logic                 w_ovf;
  logic [REC_W-1:0]     w_rec;

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Mask lookup by explicit compare so out-of-range indices never qualify
  always_comb begin
    w_mask_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_OSC; i++) begin
      if (bus.smp_osc_i == IDX_W'(i)) w_mask_hit = osc_mask_i[i];
    end
  end

  assign w_qual     = bus.smp_valid_i & w_mask_hit;
  assign w_ext      = {bus.smp_out_i[SAMPLE_W-1], bus.smp_out_i};
  assign w_mag      = w_ext[SAMPLE_W] ? (~w_ext + 1'b1) : w_ext;
  assign w_trig     = w_qual & (bus.smp_osc_i == trig_osc_i) & (w_mag >= {1'b0, trig_level_i});
  assign w_rd_valid = (r_count != '0);
  assign w_pop      = w_rd_valid & bus.rd_ready_i;
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_ovf      = w_wr & ~w_pop & w_full;
  assign w_rec      = {bus.smp_osc_i, bus.smp_state_i, bus.smp_vol_i, bus.smp_wds_i, bus.smp_out_i};

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state: stop beats a same-cycle write; one-shot ends on the filling write
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (arm_i) w_state_nxt = S_ARMED;
      S_ARMED: begin
        if (stop_i)    w_state_nxt = S_IDLE;
        else if (w_wr) w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (stop_i) w_state_nxt = S_DONE;
        else if (w_wr && !r_mode && !w_pop && (r_count == CNT_W'(DEPTH - 1)))
          w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs and buffer write/clear strobes
  always_comb begin
    w_wr    = 1'b0;
    w_clear = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: w_clear = arm_i;
      S_ARMED:        w_wr    = ~stop_i & w_trig;
      S_CAPTURE:      w_wr    = ~stop_i & w_qual;
      default: ;
    endcase
    state_o = r_state;
    done_o  = (r_state == S_DONE);
  end

  // Pointers, occupancy and drop counter; a full ring write advances the head
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
      r_mode   <= 1'b0;
    end else if (w_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
      r_mode   <= mode_i;
    end else begin
      if (w_wr)          r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_pop || w_ovf) r_rd_ptr <= f_inc(r_rd_ptr);
      if (w_wr && !w_pop && !w_full) r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_wr)       r_count <= r_count - CNT_W'(1);
      if (w_ovf && (r_drop != '1))   r_drop  <= r_drop + 16'd1;
    end
  end

  // Record storage, not reset
  always_ff @(posedge clk_i) begin
    if (w_wr && !reset_i) r_mem[r_wr_ptr] <= w_rec;
  end

  assign count_o       = r_count;
  assign drop_cnt_o    = r_drop;
  assign bus.rd_valid_o = w_rd_valid;
  assign bus.rd_data_o  = r_mem[r_rd_ptr];
endmodule

// File: doc/doc_trace_capture.md
DOC_TRACE_CAPTURE -- requirements
Module: doc_trace_capture

Interface
REQ-001 Parameter NUM_OSC, default 32: oscillator slots per sound-generator scan; legal range 1..32.
REQ-002 Parameter DEPTH, default 64: trace buffer entries; legal range >= 2, need not be a power of two.
REQ-003 Parameter SAMPLE_W, default 16: signed oscillator output sample width.
REQ-004 Derived widths: IDX_W = max(1, clog2(NUM_OSC)); CNT_W = clog2(DEPTH+1); REC_W = IDX_W+3+8+8+SAMPLE_W.
REQ-005 clk_i  in  1  single clock; all logic on its rising edge.
REQ-006 reset_i  in  1  synchronous, active-high reset.
REQ-007 smp_valid_i  in  1  one oscillator sample presented this cycle.
REQ-008 smp_osc_i  in  IDX_W  oscillator index of the sample.
REQ-009 smp_state_i / smp_vol_i / smp_wds_i  in  3 / 8 / 8  oscillator state, volume, wave data.
REQ-010 smp_out_i  in  SAMPLE_W  signed oscillator output.
REQ-011 osc_mask_i  in  NUM_OSC  bit n set = samples from oscillator n qualify.
REQ-012 mode_i  in  1  0 = one-shot, 1 = continuous (ring, overwrite oldest).
REQ-013 trig_osc_i  in  IDX_W / trig_level_i  in  SAMPLE_W  trigger oscillator and unsigned magnitude threshold.
REQ-014 arm_i, stop_i  in  1  single-cycle control strobes.
REQ-015 state_o  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-016 done_o  out  1  high while state is DONE.
REQ-017 count_o  out  CNT_W  entries held; drop_cnt_o  out  16  entries overwritten since arm.
REQ-018 rd_valid_o  out  1, rd_ready_i  in  1, rd_data_o  out  REC_W  FWFT read port; record = {osc, state, vol, wds, out}, osc in MSBs.

Function
REQ-019 Qualifying sample: smp_valid_i=1 and osc_mask_i[smp_osc_i]=1; smp_osc_i >= NUM_OSC never qualifies.
REQ-020 Trigger: qualifying sample with smp_osc_i == trig_osc_i and |smp_out_i| >= trig_level_i, magnitude computed in SAMPLE_W+1 bits (most-negative value has full magnitude).
REQ-021 IDLE/DONE + arm_i: next state ARMED; count, pointers, drop_cnt cleared; mode_i latched and held until next arm.
REQ-022 arm_i in ARMED or CAPTURE is ignored.
REQ-023 ARMED: trigger sample is written as the first entry and state goes CAPTURE; non-trigger samples are discarded.
REQ-024 CAPTURE: every qualifying sample is written; count_o reflects a write on the following cycle.
REQ-025 One-shot: write making count == DEPTH moves state to DONE same edge; no further writes.
REQ-026 Continuous, buffer full, write without pop: oldest entry discarded, read pointer advances, drop_cnt_o += 1 (saturates at 0xFFFF), count stays DEPTH.
REQ-027 Write and pop same cycle: count unchanged, drop_cnt unchanged, even when full.
REQ-028 stop_i: ARMED -> IDLE; CAPTURE -> DONE; stop_i has priority over a same-cycle write; no effect in IDLE/DONE.
REQ-029 Simultaneous arm_i and stop_i: in IDLE/DONE arm applies; elsewhere stop applies.
REQ-030 rd_valid_o = (count_o != 0) in every state; rd_data_o = head entry while rd_valid_o=1; pop on rd_valid_o & rd_ready_i.
REQ-031 rd_ready_i with empty buffer is ignored; buffer contents remain readable in DONE and IDLE until next arm.
REQ-032 Pointers wrap from DEPTH-1 to 0.

Reset
REQ-033 reset_i=1 at an edge: state IDLE, count 0, pointers 0, drop_cnt 0, latched mode 0; rd_valid_o=0, done_o=0; a sample or strobe in that cycle is ignored.
REQ-034 Reset mid-capture discards all entries; memory contents need not be cleared.

Verification
REQ-035 One-shot, DEPTH=4, mask=all, trig_osc=3, level=0x0100: samples osc3 out=0x0080 then osc3 out=-0x0200 -> trigger on second; 3 more samples -> DONE, count=4, first read record out=-0x0200 (0xFE00).
REQ-036 Continuous, DEPTH=4, 6 writes, no reads -> count=4, drop_cnt=2, reads return writes 3..6 in order then rd_valid_o=0.
REQ-037 Continuous full with rd_ready_i=1 and write each cycle for 10 cycles -> count stays 4, drop_cnt stays 0.
REQ-038 mask=0x00000004, samples from osc 1,2,5 in CAPTURE -> only osc 2 entries stored.
REQ-039 stop_i and qualifying sample same cycle in CAPTURE with count=2 -> DONE, count=2; then reset_i mid-ARMED -> IDLE, count 0.
REQ-040 NUM_OSC=5, DEPTH=3: smp_osc_i=6 never stored; pointer wrap verified over 7 write/read pairs with data intact.
